reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised board-level reset manager that sits between the PLL and all clocked logic in the top-level board wrapper.
- Holds N downstream reset domains in reset until the PLL is locked, the reset key is released (debounced) and a power-on hold time has elapsed.
- Releases the domains one at a time, channel 0 first, with a fixed gap between releases.
- Re-asserts all domain resets on PLL lock loss or key press, and reports lock-loss events.

Parameters:
- CHANNELS, 3: number of reset domains driven; legal range 1..16.
- HOLD_CYCLES, 1024: clock cycles spent in HOLD before the first release; must be >= 1.
- STAGE_GAP, 16: clock cycles between successive channel releases, and from the last release to ready; must be >= 1.
- DEBOUNCE, 4096: consecutive stable synchronised samples required to change the debounced key state; must be >= 1.

Ports:
- clock  input  1  system clock (PLL 50 MHz output).
- reset_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL lock indication; asynchronous to clock.
- key_n  input  1  reset push-button, active-low, asynchronous and bouncy.
- rst_n_out  output  CHANNELS  per-domain active-low resets; bit 0 is released first.
- ready  output  1  high once all channels are released plus STAGE_GAP cycles.
- lock_lost  output  1  sticky flag; set when lock drops after HOLD has been entered.

Behaviour:
- Reset is asynchronous and active-low. One clock domain only.
- Reset values: rst_n_out = 0, ready = 0, lock_lost = 0, state = WAIT_LOCK, all counters = 0, debounced key = released, synchroniser flops = 0 (key sync = 1).
- Synchronisers: pll_locked and key_n each pass through a 2-flop synchroniser (2-cycle latency) to give lock_s and key_s.
- Debounce: key_pressed changes value only after key_s has held the opposite value for DEBOUNCE consecutive cycles. Any glitch restarts the count.
- WAIT_LOCK: all rst_n_out = 0, ready = 0. Go to HOLD (counter cleared) when lock_s = 1 and key_pressed = 0.
- HOLD: counter increments each cycle. At count HOLD_CYCLES-1, go to RELEASE with idx = 0.
- RELEASE: per channel, in order 0 to CHANNELS-1:
  - Let H be the clock edge on which the state becomes HOLD.
  - rst_n_out[k] rises at edge H + HOLD_CYCLES + k*STAGE_GAP.
  - Released bits stay high.
- RUN: ready rises at edge H + HOLD_CYCLES + CHANNELS*STAGE_GAP. The block stays in RUN indefinitely.
- Abort rule: in HOLD, RELEASE or RUN, if lock_s = 0 or key_pressed = 1 is sampled:
  - On the next edge, all rst_n_out go to 0 together, ready goes to 0, counters clear and state returns to WAIT_LOCK.
  - Resets assert synchronously to clock; assertion is never staged.
- lock_lost:
  - Set on the abort edge when the cause includes lock_s = 0.
  - Cleared on the edge where key_pressed rises, or by reset_n.
  - If lock loss and key press are sampled in the same cycle: the abort occurs and lock_lost is set; it is not cleared in that cycle.
- Lock lost while already in WAIT_LOCK: no effect on lock_lost.
- Counter width: $clog2 of max(HOLD_CYCLES, STAGE_GAP, DEBOUNCE) + 1. No wrap in any state.
- reset_n asserted mid-sequence: immediate return to the reset values listed above.

Optional Feature:
- Macro: RESET_SEQUENCER_LOSS_COUNT_EN.
- With the macro defined:
  - Extra output port loss_count, 8 bits, reset value 0.
  - Increments on every abort edge caused by lock loss.
  - Saturates at 255.
  - Unaffected by key press; cleared only by reset_n.
- Without the macro: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package reset_sequencer_pkg contains:
  - the state typedef enum {WAIT_LOCK, HOLD, RELEASE, RUN};
  - the counter-width constant function;
  - the loss-counter width (8) and saturation value (255).
- One natural sub-module: sync_debounce, a 2-flop synchroniser plus debounce counter with parameter DEBOUNCE and reset value parameter.
  - Instantiated for key_n.
  - pll_locked uses a plain 2-flop synchroniser, not debounced.

Test Plan:
All scenarios use CHANNELS=3, HOLD_CYCLES=8, STAGE_GAP=4, DEBOUNCE=4.
- Lock rising: reset_n released, key_n = 1, pll_locked raised before edge E.
  - HOLD entered at E+2.
  - rst_n_out becomes 001 at E+10, 011 at E+14, 111 at E+18.
  - ready = 1 at E+22.
  - lock_lost stays 0.
- Lock loss in RUN: drop pll_locked in RUN.
  - 3 cycles later, rst_n_out = 000, ready = 0, lock_lost = 1.
  - Re-raise pll_locked: full sequence repeats with the same offsets; lock_lost stays 1.
- Key debounce and clear: key_n pulses low for 3 cycles in RUN.
  - No abort.
  - Then key_n held low for 4 cycles: abort after sync + debounce; lock_lost clears.
  - Release key: sequence restarts.
- Lock loss during RELEASE: drop pll_locked when rst_n_out = 011.
  - All bits return to 000 together on one edge, never 001.
- Mid-sequence reset: assert reset_n in HOLD.
  - Outputs are 0 asynchronously (before the next edge).
  - State returns to WAIT_LOCK.
- Loss count (with RESET_SEQUENCER_LOSS_COUNT_EN): 300 lock-loss aborts.
  - loss_count = 255.
  - Key press leaves it at 255.
  - reset_n clears it to 0.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the board reset sequencer.
// Used by reset_sequencer and its key debouncer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = 8'd255;

  // Wide enough to reach the largest terminal count without wrapping.
  function automatic int cnt_width(input int hold, input int gap, input int deb);
    int m;
    m = hold;
    if (gap > m) m = gap;
    if (deb > m) m = deb;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchroniser followed by a debounce counter.
// 'change' is high in the cycle before 'level' toggles.
module sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int   DEBOUNCE = 4096,
  parameter logic RST_VAL  = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic change
);

  localparam int W = cnt_width(1, 1, DEBOUNCE);

  logic         sync_p1;
  logic         sync_p2;
  logic [W-1:0] cnt;

  assign change = (sync_p2 != level) && (cnt == W'(DEBOUNCE - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p1 <= RST_VAL;
      sync_p2 <= RST_VAL;
      level   <= RST_VAL;
      cnt     <= '0;
    end else begin
      sync_p1 <= din;
      sync_p2 <= sync_p1;
      // Any sample matching the current level restarts the count.
      if (sync_p2 != level) begin
        if (change) begin
          level <= sync_p2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset manager: holds domains in reset until PLL lock, key release and a
// hold time, then releases them one by one. RESET_SEQUENCER_LOSS_COUNT_EN adds loss_count.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int HOLD_CYCLES = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int DEBOUNCE    = 4096
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                key_n,
  output logic [CHANNELS-1:0] rst_n_out,
  output logic                ready,
  output logic                lock_lost
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
  ,
  output logic [LOSS_W-1:0]   loss_count
`endif
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, DEBOUNCE);

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic           lock_p1;
  logic           lock_s;
  logic           key_level;
  logic           key_change;
  logic           key_pressed;
  logic           key_press_edge;
  logic           active;
  logic           abort;
  logic           lock_drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_p1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p1 <= pll_locked;
      lock_s  <= lock_p1;
    end
  end

  sync_debounce #(
    .DEBOUNCE(DEBOUNCE),
    .RST_VAL (1'b1)
  ) u_key (
    .clock  (clock),
    .reset_n(reset_n),
    .din    (key_n),
    .level  (key_level),
    .change (key_change)
  );

  assign key_pressed    = ~key_level;
  assign key_press_edge = key_change & key_level;
  assign active         = (state != WAIT_LOCK);
  assign abort          = active && (!lock_s || key_pressed);
  assign lock_drop      = active && !lock_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rst_n_out <= '0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      // Abort drops every domain together on a single edge.
      if (abort) begin
        state     <= WAIT_LOCK;
        cnt       <= '0;
        rst_n_out <= '0;
        ready     <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            cnt <= '0;
            if (lock_s && !key_pressed) state <= HOLD;
          end
          HOLD: begin
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              state     <= RELEASE;
              cnt       <= '0;
              rst_n_out <= CHANNELS'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RELEASE: begin
            // Released bits are contiguous from bit 0, so a shift-in-one releases the next.
            if (cnt == CNT_W'(STAGE_GAP - 1)) begin
              cnt <= '0;
              if (rst_n_out[CHANNELS-1]) begin
                state <= RUN;
                ready <= 1'b1;
              end else begin
                rst_n_out <= (rst_n_out << 1) | CHANNELS'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: ready <= 1'b1;
          default: state <= WAIT_LOCK;
        endcase
      end

      // A simultaneous lock drop wins over the key-press clear.
      if (lock_drop)           lock_lost <= 1'b1;
      else if (key_press_edge) lock_lost <= 1'b0;
    end
  end

`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loss_count <= '0;
    end else if (lock_drop && (loss_count != LOSS_MAX)) begin
      loss_count <= loss_count + LOSS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer with CHANNELS=3, HOLD_CYCLES=8, STAGE_GAP=4, DEBOUNCE=4.
// Stimulus queues expected output changes with their edge number; a monitor pops and compares.
module tb_reset_sequencer;

  localparam int CH = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          pll_locked;
  logic          key_n;
  logic [CH-1:0] rst_n_out;
  logic          ready;
  logic          lock_lost;
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
  logic [7:0]    loss_count;
`endif

  reset_sequencer #(
    .CHANNELS   (CH),
    .HOLD_CYCLES(8),
    .STAGE_GAP  (4),
    .DEBOUNCE   (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .key_n     (key_n),
    .rst_n_out (rst_n_out),
    .ready     (ready),
    .lock_lost (lock_lost)
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
    ,
    .loss_count(loss_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            at;
    logic [CH-1:0] r;
    logic          rdy;
    logic          ll;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
  typedef struct {
    int         at;
    logic [7:0] val;
  } lc_t;
  lc_t lq[$];

  task automatic expect_loss(input int at, input logic [7:0] val);
    lc_t e;
    e.at  = at;
    e.val = val;
    lq.push_back(e);
  endtask
`endif

  task automatic expect_at(input int at, input logic [CH-1:0] r, input logic rdy, input logic ll);
    exp_t e;
    e.at  = at;
    e.r   = r;
    e.rdy = rdy;
    e.ll  = ll;
    q.push_back(e);
  endtask

  // Release timeline for lock first seen by the synchroniser at edge e (HOLD entered at e+2).
  task automatic seq(input int e, input logic ll);
    expect_at(e + 10, 3'b001, 1'b0, ll);
    expect_at(e + 14, 3'b011, 1'b0, ll);
    expect_at(e + 18, 3'b111, 1'b0, ll);
    expect_at(e + 22, 3'b111, 1'b1, ll);
  endtask

  task automatic go(input int c);
    do @(negedge clock); while (cyc < c);
  endtask

  // Monitor: every change of the observable outputs must match the next queued event.
  logic [CH+1:0] prev;
  bit            first = 1'b1;
  always @(negedge clock) begin
    logic [CH+1:0] cur;
    exp_t          e;
    cur = {rst_n_out, ready, lock_lost};
    if (first || (cur !== prev)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change edge=%0d got=%b", cyc, cur);
      end else begin
        e = q.pop_front();
        if ((e.at != cyc) || (cur !== {e.r, e.rdy, e.ll})) begin
          n_bad++;
          $display("FAIL output_event got edge=%0d {rst,rdy,ll}=%b required edge=%0d {rst,rdy,ll}=%b",
                   cyc, cur, e.at, {e.r, e.rdy, e.ll});
        end
      end
      prev  = cur;
      first = 1'b0;
    end
`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
    while ((lq.size() > 0) && (lq[0].at <= cyc)) begin
      lc_t l;
      l = lq.pop_front();
      n_cmp++;
      if ((l.at != cyc) || (loss_count !== l.val)) begin
        n_bad++;
        $display("FAIL loss_count edge=%0d got=%0d required=%0d at edge %0d", cyc, loss_count, l.val, l.at);
      end
    end
`endif
    if (done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_event required edge=%0d {rst,rdy,ll}=%b got none", e.at, {e.r, e.rdy, e.ll});
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int d;
    int k;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    key_n      = 1'b1;
    expect_at(1, 3'b000, 1'b0, 1'b0);
    go(3);
    reset_n = 1'b1;

    // Lock rising: full release sequence.
    e = cyc + 1;
    pll_locked = 1'b1;
    seq(e, 1'b0);
    go(e + 25);

    // Lock loss in RUN, then recovery with lock_lost held.
    d = cyc + 1;
    pll_locked = 1'b0;
    expect_at(d + 2, 3'b000, 1'b0, 1'b1);
    go(d + 5);
    e = cyc + 1;
    pll_locked = 1'b1;
    seq(e, 1'b1);
    go(e + 25);

    // Three-cycle key glitch is filtered out.
    k = cyc + 1;
    key_n = 1'b0;
    go(k + 2);
    key_n = 1'b1;
    go(k + 12);

    // Four-cycle key press: debounce, clear lock_lost, abort, then restart after release.
    k = cyc + 1;
    key_n = 1'b0;
    go(k + 3);
    key_n = 1'b1;
    expect_at(k + 5, 3'b111, 1'b1, 1'b0);
    expect_at(k + 6, 3'b000, 1'b0, 1'b0);
    seq(k + 8, 1'b0);
    go(k + 33);

    // Lock loss during RELEASE at 011: one edge back to 000.
    d = cyc + 1;
    pll_locked = 1'b0;
    expect_at(d + 2, 3'b000, 1'b0, 1'b1);
    go(d + 5);
    e = cyc + 1;
    pll_locked = 1'b1;
    expect_at(e + 10, 3'b001, 1'b0, 1'b1);
    expect_at(e + 14, 3'b011, 1'b0, 1'b1);
    go(e + 14);
    pll_locked = 1'b0;
    expect_at(e + 17, 3'b000, 1'b0, 1'b1);
    go(e + 22);

    // Reset asserted in HOLD clears lock_lost before the next edge.
    e = cyc + 1;
    pll_locked = 1'b1;
    go(e + 4);
    @(posedge clock);
    #2;
    expect_at(cyc, 3'b000, 1'b0, 1'b0);
    reset_n = 1'b0;
    go(cyc + 2);
    reset_n = 1'b1;
    e = cyc + 1;
    seq(e, 1'b0);
    go(e + 25);

    // Reset asserted in RUN clears all outputs before the next edge.
    @(posedge clock);
    #2;
    expect_at(cyc, 3'b000, 1'b0, 1'b0);
    reset_n = 1'b0;
    go(cyc + 2);
    reset_n = 1'b1;
    e = cyc + 1;
    seq(e, 1'b0);
    go(e + 25);

`ifdef RESET_SEQUENCER_LOSS_COUNT_EN
    // 300 lock-loss aborts saturate the counter at 255.
    d = cyc + 1;
    pll_locked = 1'b0;
    expect_at(d + 2, 3'b000, 1'b0, 1'b1);
    expect_loss(d + 3, 8'd1);
    go(d + 5);
    for (int i = 1; i < 300; i++) begin
      e = cyc + 1;
      pll_locked = 1'b1;
      go(e + 2);
      pll_locked = 1'b0;
      go(e + 5);
      if (i == 9) expect_loss(cyc + 1, 8'd10);
    end
    expect_loss(cyc + 1, 8'd255);
    go(cyc + 3);
    k = cyc + 1;
    key_n = 1'b0;
    go(k + 5);
    key_n = 1'b1;
    expect_at(k + 5, 3'b000, 1'b0, 1'b0);
    go(k + 12);
    expect_loss(cyc + 1, 8'd255);
    go(cyc + 2);
    @(posedge clock);
    #2;
    expect_loss(cyc, 8'd0);
    reset_n = 1'b0;
    go(cyc + 2);
    reset_n = 1'b1;
`endif

    go(cyc + 10);
    done = 1'b1;
  end

endmodule
